// File: rtl/arith_seq_pkg.sv
// rtl/arith_seq_pkg.sv - op encodings and controller state type for arith_sequencer
package arith_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_B2A = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP1,
    S_STEP2,
    S_MUL_LOOP,
    S_DONE
  } state_t;

endpackage

// File: rtl/adder_subtractor_16bit.sv
// rtl/adder_subtractor_16bit.sv - combinational 16-bit adder; cin=1 selects a - b
module adder_subtractor_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [15:0] w_b_eff;

  // cin doubles as subtract select: a + ~b + 1 is two's-complement a - b
  assign w_b_eff = i_b ^ {16{i_cin}};
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {16'b0, i_cin};

endmodule

// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - multi-cycle ADD/SUB/B-2A/MUL controller sharing one adder
module arith_sequencer
  import arith_seq_pkg::*;
#(
  parameter int MUL_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        carry_out
);

  localparam logic [7:0] MUL_MASK = 8'((16'd1 << MUL_BITS) - 16'd1);
  localparam logic [3:0] CNT_LAST = 4'(MUL_BITS - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_tmp;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [3:0]  r_cnt;
  logic [15:0] r_result;
  logic        r_carry;

  logic [15:0] w_add_a;
  logic [15:0] w_add_b;
  logic        w_add_cin;
  logic [15:0] w_sum;
  logic        w_cout;
  logic        w_accept;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign carry_out = r_carry;
  assign w_accept  = in_valid && in_ready;

  adder_subtractor_16bit u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_add_a      = 16'h0000;
    w_add_b      = 16'h0000;
    w_add_cin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = (op == OP_MUL) ? S_MUL_LOOP : S_STEP1;
      end
      S_STEP1: begin
        w_add_a = r_a;
        case (r_op)
          OP_SUB: begin
            w_add_b      = r_b;
            w_add_cin    = 1'b1;
            w_next_state = S_DONE;
          end
          OP_B2A: begin
            w_add_b      = r_a;
            w_next_state = S_STEP2;
          end
          default: begin
            w_add_b      = r_b;
            w_next_state = S_DONE;
          end
        endcase
      end
      S_STEP2: begin
        w_add_a      = r_b;
        w_add_b      = r_tmp;
        w_add_cin    = 1'b1;
        w_next_state = S_DONE;
      end
      S_MUL_LOOP: begin
        w_add_a = r_acc;
        w_add_b = r_mplier[0] ? r_mcand : 16'h0000;
        if (r_cnt == CNT_LAST) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_tmp    <= 16'h0000;
      r_acc    <= 16'h0000;
      r_mcand  <= 16'h0000;
      r_mplier <= 8'h00;
      r_cnt    <= 4'd0;
      r_result <= 16'h0000;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
            if (op == OP_MUL) begin
              r_acc    <= 16'h0000;
              r_mcand  <= {8'h00, a[7:0]};
              r_mplier <= b[7:0] & MUL_MASK;
              r_cnt    <= 4'd0;
            end
          end
        end
        S_STEP1: begin
          // B-2A parks 2a in tmp; its carry is meaningless and dropped
          if (r_op == OP_B2A) begin
            r_tmp <= w_sum;
          end else begin
            r_result <= w_sum;
            r_carry  <= w_cout;
          end
        end
        S_STEP2: begin
          r_result <= w_sum;
          r_carry  <= w_cout;
        end
        S_MUL_LOOP: begin
          r_acc    <= w_sum;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[7:1]};
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == CNT_LAST) begin
            r_result <= w_sum;
            r_carry  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/arith_sequencer.md
Name: arith_sequencer

Overview:
- Multi-cycle controller that time-shares one existing `adder_subtractor_16bit` instance across four operations: ADD, SUB, B_MINUS_2A and an unsigned 8x8 shift-add multiply.
- Accepts one command at a time over a valid/ready handshake, sequences the adder's operands and carry-in cycle by cycle, and holds the result until the consumer takes it.
- Sits between the lab's top-level control logic and the combinational arithmetic datapath.

Parameters:
- MUL_BITS, 8, number of low operand bits used by MUL. Legal range is 1..8. MUL latency equals MUL_BITS cycles.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command.
- op  input  2  operation select: 00 ADD, 01 SUB, 10 B_MINUS_2A, 11 MUL.
- a  input  16  operand A; captured at accept.
- b  input  16  operand B; captured at accept.
- out_valid  output  1  result and carry_out are valid.
- out_ready  input  1  consumer takes the result.
- result  output  16  operation result.
- carry_out  output  1  adder carry-out of the final step; 0 for MUL.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, including mid-operation):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, result=0, carry_out=0.
  - All operand, accumulator and counter registers are cleared.
- Accept occurs when in_valid & in_ready at a rising edge. op, a and b are registered; inputs are ignored at all other times.
- in_ready = (state==IDLE). No command is accepted in the same cycle a result is consumed.
- States: IDLE, STEP1, STEP2, MUL_LOOP, DONE.
- IDLE transitions on accept:
  - ADD/SUB/B_MINUS_2A go to STEP1.
  - MUL goes to MUL_LOOP with acc=0, mcand={8'b0, a[7:0]}, mplier=b[MUL_BITS-1:0], cnt=0.
- STEP1, ADD: adder inputs (a, b, cin=0). result<=sum, carry_out<=cout. Next state DONE.
- STEP1, SUB: adder inputs (a, b, cin=1), i.e. a-b in two's complement. carry_out=1 means no borrow. Next state DONE.
- STEP1, B_MINUS_2A: adder inputs (a, a, cin=0). Store tmp<=sum and discard cout. Next state STEP2.
- STEP2: adder inputs (b, tmp, cin=1). result<=sum, carry_out<=cout. Next state DONE.
- MUL_LOOP, each cycle:
  - Adder inputs are (acc, mplier[0] ? mcand : 0, cin=0); acc<=sum.
  - mcand<<=1, mplier>>=1, cnt++.
  - When cnt==MUL_BITS-1, also load result<=sum, set carry_out<=0, and go to DONE.
- DONE: out_valid=1, and result/carry_out are held stable.
  - out_ready=1 goes to IDLE; out_valid drops the next cycle.
  - out_ready=0 holds DONE indefinitely.
- Latency is counted from the accept edge to the first cycle with out_valid=1:
  - ADD/SUB: 1 cycle.
  - B_MINUS_2A: 2 cycles.
  - MUL: MUL_BITS cycles.
- Arithmetic is 16-bit modular; intermediate overflow of a+a is silently discarded.
- MUL ignores a[15:8] and b[15:MUL_BITS]. The full 16-bit product cannot overflow.
- When the adder is idle (IDLE/DONE), its inputs are driven to 0 and cin to 0. This value is don't-care for correctness.
- Throughput: back-to-back commands are separated by at least one IDLE cycle.

Decomposition:
- Package `arith_seq_pkg` holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_B2A=2'b10, OP_MUL=2'b11.
  - The state enum.
- Sub-module: one instance of the existing `adder_subtractor_16bit`. No new sub-modules.
- Controller FSM and datapath registers live in `arith_sequencer`, about 150-250 lines.

Test Plan:
- ADD, a=0x1234, b=0x0FFF, out_ready=1 -> result=0x2233, carry_out=0, out_valid 1 cycle after accept for exactly 1 cycle.
- SUB, a=0x0005, b=0x0007 -> 0xFFFE, carry_out=0. Then SUB a=0x0007, b=0x0005 -> 0x0002, carry_out=1.
- B_MINUS_2A, a=0x0003, b=0x0010 -> 0x000A, carry_out=1, latency 2. Then a=0x8000, b=0x0000 -> 0x0000, carry_out=1.
- MUL, a=0x00FF, b=0x00FF -> 0xFE01, carry_out=0, latency 8. Then a=0xAB03, b=0xCD05 -> 0x000F (upper bits ignored).
- Backpressure: hold out_ready=0 for 5 cycles after an ADD completes while toggling in_valid/a/b -> result, out_valid=1 and in_ready=0 stay stable, no new accept. Release -> IDLE, next command accepted.
- Assert rst_n=0 on the 4th MUL_LOOP cycle -> out_valid/result/carry_out go to 0 immediately. After release, in_ready=1 and a fresh ADD 1+1 returns 0x0002.
